// File: rtl/instr_mem_bank_wrap.sv
// Instruction memory wrapper: word-interleaved RAM banks plus a boot ROM, shared by a
// read-only fetch port and a read/write loader port with loader-priority arbitration.
module instr_mem_bank_wrap #(
   parameter int RAM_SIZE       = 32768,
   parameter int NUM_BANKS      = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = $clog2(RAM_SIZE) + 1,
   parameter int ROM_ADDR_WIDTH = 12,
   parameter int MAX_STALL      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    f_req_i,
   input  logic [ADDR_WIDTH-1:0]   f_addr_i,
   output logic                    f_gnt_o,
   output logic                    f_rvalid_o,
   output logic [DATA_WIDTH-1:0]   f_rdata_o,
   output logic                    f_err_o,
   input  logic                    l_req_i,
   input  logic                    l_we_i,
   input  logic [DATA_WIDTH/8-1:0] l_be_i,
   input  logic [ADDR_WIDTH-1:0]   l_addr_i,
   input  logic [DATA_WIDTH-1:0]   l_wdata_i,
   output logic                    l_gnt_o,
   output logic                    l_rvalid_o,
   output logic [DATA_WIDTH-1:0]   l_rdata_o,
   output logic                    l_err_o,
   input  logic                    bypass_en_i
);

   localparam int BE_W      = DATA_WIDTH / 8;
   localparam int WORD_LSB  = $clog2(BE_W);
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int ROWS      = RAM_SIZE / BE_W / NUM_BANKS;
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WORD_W    = ADDR_WIDTH - 1 - WORD_LSB;
   localparam int TGT_W     = $clog2(NUM_BANKS + 2);
   localparam int CNT_W     = $clog2(MAX_STALL + 1);
   localparam int ROM_IDX_W = ROM_ADDR_WIDTH - WORD_LSB;

   // Target ids: banks are 0..NUM_BANKS-1, then the ROM, then "nothing" (RAM out of range)
   localparam logic [TGT_W-1:0] TGT_ROM  = TGT_W'(NUM_BANKS);
   localparam logic [TGT_W-1:0] TGT_NONE = TGT_W'(NUM_BANKS + 1);

   function automatic logic [TGT_W-1:0] dec_tgt(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      logic [WORD_W-1:0]     word;
      off  = {1'b0, a[ADDR_WIDTH-2:0]};
      word = a[ADDR_WIDTH-2:WORD_LSB];
      if (a[ADDR_WIDTH-1])
         dec_tgt = TGT_ROM;
      else if (off >= ADDR_WIDTH'(RAM_SIZE))
         dec_tgt = TGT_NONE;
      else
         dec_tgt = TGT_W'(word & WORD_W'(NUM_BANKS - 1));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ROM_IDX_W-1:0] idx);
      rom_word = DATA_WIDTH'(32'hB007_0000) | DATA_WIDTH'({idx, {WORD_LSB{1'b0}}});
   endfunction

   logic [TGT_W-1:0]      f_tgt, l_tgt;
   logic [ROW_W-1:0]      f_row, l_row;
   logic                  blk, conflict, f_wins, f_gnt, l_gnt, f_err, l_err;
   logic [CNT_W-1:0]      stall_cnt;
   logic                  rst_hold_q;
   logic                  f_vld_p1, f_err_p1, l_vld_p1, l_err_p1, l_wr_p1;
   logic [TGT_W-1:0]      f_tgt_p1, l_tgt_p1;
   logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];
   logic [DATA_WIDTH-1:0] rom_q, f_rd, l_rd;
   logic                  rom_en;
   logic [ROM_IDX_W-1:0]  rom_idx;

   assign f_tgt = dec_tgt(f_addr_i);
   assign l_tgt = dec_tgt(l_addr_i);
   assign f_row = ROW_W'(f_addr_i[ADDR_WIDTH-2:WORD_LSB] >> BANK_BITS);
   assign l_row = ROW_W'(l_addr_i[ADDR_WIDTH-2:WORD_LSB] >> BANK_BITS);

   // Grants stay low during reset and for the first cycle after it releases
   assign blk      = rst | rst_hold_q;
   assign conflict = f_req_i & l_req_i & (f_tgt == l_tgt) & (f_tgt != TGT_NONE);
   assign f_wins   = (stall_cnt == CNT_W'(MAX_STALL));
   assign f_gnt    = f_req_i & ~blk & ~(conflict & ~f_wins);
   assign l_gnt    = l_req_i & ~blk & ~(conflict & f_wins);
   assign f_err    = (f_tgt == TGT_NONE);
   assign l_err    = (l_tgt == TGT_NONE) | ((l_tgt == TGT_ROM) & l_we_i);
   assign f_gnt_o  = f_gnt;
   assign l_gnt_o  = l_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_hold_q <= 1'b1;
         stall_cnt  <= '0;
      end else begin
         rst_hold_q <= 1'b0;
         if (f_gnt)
            stall_cnt <= '0;
         else if (f_req_i && !blk && !f_wins)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // ---- grant -> response stage (p1) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_vld_p1 <= 1'b0;
         f_err_p1 <= 1'b0;
         f_tgt_p1 <= '0;
         l_vld_p1 <= 1'b0;
         l_err_p1 <= 1'b0;
         l_wr_p1  <= 1'b0;
         l_tgt_p1 <= '0;
      end else begin
         f_vld_p1 <= f_gnt;
         f_err_p1 <= f_gnt & f_err;
         f_tgt_p1 <= f_tgt;
         l_vld_p1 <= l_gnt;
         l_err_p1 <= l_gnt & l_err;
         l_wr_p1  <= l_gnt & l_we_i;
         l_tgt_p1 <= l_tgt;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [ROWS];
      logic [DATA_WIDTH-1:0] rd_q, wd;
      logic [ROW_W-1:0]      row;
      logic                  l_hit, f_hit, en, we;

      always_comb begin
         l_hit = l_gnt & (l_tgt == TGT_W'(b));
         f_hit = f_gnt & (f_tgt == TGT_W'(b));
         en    = l_hit | f_hit;
         we    = l_hit & l_we_i;
         row   = l_hit ? l_row : f_row;
         wd    = l_hit ? l_wdata_i : '0;
      end

      // Bypass routes the bank's write-data input straight to its read register
      always_ff @(posedge clk) begin
         if (en) begin
            for (int i = 0; i < BE_W; i++)
               if (we && l_be_i[i]) mem[row][8*i +: 8] <= wd[8*i +: 8];
            rd_q <= bypass_en_i ? wd : mem[row];
         end
      end

      assign bank_rd[b] = rd_q;
   end

   // A loader write aimed at the ROM is answered with an error and never touches it
   always_comb begin
      rom_en  = (f_gnt & (f_tgt == TGT_ROM)) | (l_gnt & (l_tgt == TGT_ROM) & ~l_we_i);
      rom_idx = (l_gnt & (l_tgt == TGT_ROM)) ? l_addr_i[ROM_ADDR_WIDTH-1:WORD_LSB]
                                             : f_addr_i[ROM_ADDR_WIDTH-1:WORD_LSB];
   end

   always_ff @(posedge clk) begin
      if (rom_en) rom_q <= rom_word(rom_idx);
   end

   always_comb begin
      f_rd = '0;
      l_rd = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (f_tgt_p1 == TGT_W'(b)) f_rd = bank_rd[b];
         if (l_tgt_p1 == TGT_W'(b)) l_rd = bank_rd[b];
      end
      if (f_tgt_p1 == TGT_ROM) f_rd = rom_q;
      if (l_tgt_p1 == TGT_ROM) l_rd = rom_q;
   end

   assign f_rvalid_o = f_vld_p1;
   assign f_err_o    = f_err_p1;
   assign f_rdata_o  = (f_vld_p1 && !f_err_p1) ? f_rd : '0;
   assign l_rvalid_o = l_vld_p1;
   assign l_err_o    = l_err_p1;
   assign l_rdata_o  = (l_vld_p1 && !l_err_p1 && !l_wr_p1) ? l_rd : '0;

endmodule

// File: tb/tb_instr_mem_bank_wrap.sv
// Randomized bench for instr_mem_bank_wrap against a word-level memory/arbitration model.
module tb_instr_mem_bank_wrap;

   localparam int NB   = 2;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req_i, f_gnt_o, f_rvalid_o, f_err_o;
   logic [15:0] f_addr_i;
   logic [31:0] f_rdata_o;
   logic        l_req_i, l_we_i, l_gnt_o, l_rvalid_o, l_err_o;
   logic [3:0]  l_be_i;
   logic [15:0] l_addr_i;
   logic [31:0] l_wdata_i, l_rdata_o;
   logic        bypass_en_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_m [8192];
   int          denials;
   bit          blk_m;
   bit          ef_v, el_v, el_e;
   logic [31:0] ef_d, el_d;
   logic        obs_fg;

   instr_mem_bank_wrap dut (
      .clk(clk), .rst(rst),
      .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
      .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
      .l_req_i(l_req_i), .l_we_i(l_we_i), .l_be_i(l_be_i), .l_addr_i(l_addr_i),
      .l_wdata_i(l_wdata_i), .l_gnt_o(l_gnt_o), .l_rvalid_o(l_rvalid_o),
      .l_rdata_o(l_rdata_o), .l_err_o(l_err_o), .bypass_en_i(bypass_en_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int tgt_of(input logic [15:0] a);
      return a[15] ? NB : (int'(a[14:2]) % NB);
   endfunction

   function automatic logic [31:0] rom_m(input logic [15:0] a);
      return 32'hB007_0000 | {20'h0, a[11:2], 2'b00};
   endfunction

   task automatic model_reset();
      denials = 0;
      blk_m   = 1'b1;
      ef_v = 0; el_v = 0; el_e = 0;
      ef_d = '0; el_d = '0;
   endtask

   // Called just after a rising edge; applies one cycle of requests and checks it.
   task automatic step(input bit fr, input logic [15:0] fa, input bit lr, input bit lw,
                       input logic [3:0] lb, input logic [15:0] la, input logic [31:0] ld);
      int ft, lt;
      bit conf, gf, gl, nfv, nlv, nle;
      logic [31:0] nfd, nld;
      f_req_i = fr; f_addr_i = fa;
      l_req_i = lr; l_we_i = lw; l_be_i = lb; l_addr_i = la; l_wdata_i = ld;
      @(negedge clk);
      ft   = tgt_of(fa);
      lt   = tgt_of(la);
      conf = fr && lr && (ft == lt);
      gf   = fr && !blk_m && !(conf && denials < MAXS);
      gl   = lr && !blk_m && !(conf && denials >= MAXS);
      obs_fg = f_gnt_o;
      check("f_gnt", f_gnt_o, gf);
      check("l_gnt", l_gnt_o, gl);
      check("f_rvalid", f_rvalid_o, ef_v);
      check("f_rdata", f_rdata_o, ef_d);
      check("f_err", f_err_o, 1'b0);
      check("l_rvalid", l_rvalid_o, el_v);
      check("l_rdata", l_rdata_o, el_d);
      check("l_err", l_err_o, el_e);
      nfv = gf;
      nfd = '0;
      if (gf) nfd = (ft == NB) ? rom_m(fa) : (bypass_en_i ? 32'h0 : mem_m[fa[14:2]]);
      nlv = gl;
      nle = gl && lw && (lt == NB);
      nld = '0;
      if (gl && !lw) nld = (lt == NB) ? rom_m(la) : (bypass_en_i ? ld : mem_m[la[14:2]]);
      if (gl && lw && lt != NB)
         for (int i = 0; i < 4; i++)
            if (lb[i]) mem_m[la[14:2]][8*i +: 8] = ld[8*i +: 8];
      if (gf) denials = 0;
      else if (fr && !blk_m && denials < MAXS) denials++;
      blk_m = 1'b0;
      @(posedge clk);
      #1;
      ef_v = nfv; ef_d = nfd;
      el_v = nlv; el_d = nld; el_e = nle;
   endtask

   task automatic idle();
      step(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fgnt"}, f_gnt_o, 1'b0);
      check({tag, "_lgnt"}, l_gnt_o, 1'b0);
      check({tag, "_frv"}, f_rvalid_o, 1'b0);
      check({tag, "_lrv"}, l_rvalid_o, 1'b0);
      check({tag, "_frd"}, f_rdata_o, 32'h0);
      check({tag, "_lrd"}, l_rdata_o, 32'h0);
      check({tag, "_ferr"}, f_err_o, 1'b0);
      check({tag, "_lerr"}, l_err_o, 1'b0);
   endtask

   function automatic logic [15:0] rnd_addr(input bit unaligned);
      int r;
      r = $urandom_range(0, 9);
      if (r >= 8) return 16'h8000 | 16'($urandom_range(0, 15) << 2);
      return 16'(r << 2) | (unaligned ? 16'($urandom_range(0, 3)) : 16'h0);
   endfunction

   initial begin
      rst = 1'b1; bypass_en_i = 1'b0;
      f_req_i = 1'b1; f_addr_i = '0;
      l_req_i = 1'b1; l_we_i = 1'b0; l_be_i = '0; l_addr_i = 16'h4; l_wdata_i = '0;
      #2;
      check_all_zero("in_reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      idle();
      for (int w = 0; w < 8; w++) step(0, 16'h0, 1, 1, 4'hF, 16'(w << 2), $urandom);

      step(0, 16'h0, 1, 1, 4'hF, 16'h0004, 32'hDEAD_BEEF);
      step(1, 16'h0004, 0, 0, 4'h0, 16'h0, 32'h0);
      check("fetch_deadbeef", f_rdata_o, 32'hDEAD_BEEF);

      step(1, 16'h0000, 1, 0, 4'h0, 16'h0004, 32'h0);
      check("parallel_l_rdata", l_rdata_o, 32'hDEAD_BEEF);
      check("parallel_f_rvalid", f_rvalid_o, 1'b1);

      for (int i = 0; i < 6; i++) begin
         step(1, 16'h0000, 1, 0, 4'h0, 16'h0008, 32'h0);
         check("starve_gnt", obs_fg, (i == 4));
      end

      step(0, 16'h0, 1, 1, 4'hF, 16'h8010, 32'h1234_5678);
      check("rom_wr_err", l_err_o, 1'b1);
      step(1, 16'h8010, 0, 0, 4'h0, 16'h0, 32'h0);
      check("rom_unchanged", f_rdata_o, 32'hB007_0010);

      step(0, 16'h0, 1, 1, 4'hF, 16'h000C, 32'h1122_3344);
      step(0, 16'h0, 1, 1, 4'b0010, 16'h000C, 32'h0000_AB00);
      step(0, 16'h0, 1, 0, 4'h0, 16'h000C, 32'h0);
      check("byte_enable", l_rdata_o, 32'h1122_AB44);

      step(1, 16'h000E, 0, 0, 4'h0, 16'h0, 32'h0);
      check("unaligned_fetch", f_rdata_o, 32'h1122_AB44);

      bypass_en_i = 1'b1;
      step(1, 16'h0000, 1, 0, 4'h0, 16'h0004, 32'hCAFE_F00D);
      bypass_en_i = 1'b0;
      check("bypass_l", l_rdata_o, 32'hCAFE_F00D);

      step(1, 16'h0000, 0, 0, 4'h0, 16'h0, 32'h0);
      f_req_i = 1'b1; f_addr_i = 16'h0;
      #2 rst = 1'b1;
      #1 check_all_zero("mid_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step(1, 16'h0000, 1, 0, 4'h0, 16'h0004, 32'h0);
      step(1, 16'h0000, 0, 0, 4'h0, 16'h0, 32'h0);

      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 3) != 0, rnd_addr(1'b1), $urandom_range(0, 1) != 0,
              $urandom_range(0, 1) != 0, 4'($urandom), rnd_addr(1'b0), $urandom);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
